// File: rtl/tpm_pkg.sv
// Shared types and helpers for the textile-pressure-matrix row scheduler.
package tpm_pkg;

    // Scheduler phases: idle, row drive high, all-rows-low settling.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b01,
        GAP  = 2'b10
    } state_t;

    // Default drive-high and settling lengths in clock cycles.
    localparam int DEF_HOLD_CYC = 20;
    localparam int DEF_GAP_CYC  = 20;

    // Widest row vector the onehot helper can produce.
    localparam int MAX_NCH = 64;

    // One-hot vector with bit idx set; callers truncate to their row count.
    function automatic logic [MAX_NCH-1:0] onehot(input int unsigned idx);
        logic [MAX_NCH-1:0] vec;
        vec = '0;
        vec[idx[5:0]] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request bit after last_grant, wrapping.
module rr_arbiter #(
    parameter int NCH = 8,
    parameter int IW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] request,
    input  logic [IW-1:0]  last_grant,
    output logic           valid,
    output logic [IW-1:0]  idx
);

    // Scan offsets from farthest to nearest so the nearest set bit after last_grant wins.
    always_comb begin
        // NOTE: every output gets a default before any branch, so no latch can be inferred.
        valid = 1'b0;
        idx   = '0;
        for (int off = NCH; off >= 1; off--) begin
            if (request[(int'(last_grant) + off) % NCH]) begin
                valid = 1'b1;
                idx   = IW'((int'(last_grant) + off) % NCH);
            end
        end
    end

endmodule

// File: rtl/tpm_row_scheduler.sv
// Round-robin row-drive scheduler: one row at a time, HOLD_CYC high then
// GAP_CYC all-low, with an ADC sample strobe on the last high cycle.
module tpm_row_scheduler
    import tpm_pkg::*;
#(
    parameter int NCH      = 8,
    parameter int HOLD_CYC = DEF_HOLD_CYC,
    parameter int GAP_CYC  = DEF_GAP_CYC,
    parameter int CW       = 7,
    parameter int IW       = $clog2(NCH)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [NCH-1:0] trig,
    input  logic           enable,
    output logic [NCH-1:0] drive_out,
    output logic [IW-1:0]  active_idx,
    output logic           sample_strobe,
    output logic           busy
);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
    localparam logic [IW-1:0] LAST_ROW  = IW'(NCH - 1);

    state_t          state;
    state_t          state_n;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;
    logic [NCH-1:0]  pending;
    logic [NCH-1:0]  pending_n;
    logic [NCH-1:0]  grant_mask;
    logic [NCH-1:0]  drive_n;
    logic [IW-1:0]   active_idx_n;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   last_grant_n;
    logic            strobe_n;
    logic            busy_n;
    logic            do_grant;
    logic            arb_valid;
    logic [IW-1:0]   arb_idx;

    rr_arbiter #(
        .NCH (NCH),
        .IW  (IW)
    ) u_arbiter (
        .request    (pending),
        .last_grant (last_grant),
        .valid      (arb_valid),
        .idx        (arb_idx)
    );

    // Next-state, counter, grant and output decode for the scheduler FSM.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        drive_n      = drive_out;
        active_idx_n = active_idx;
        last_grant_n = last_grant;
        grant_mask   = '0;
        do_grant     = 1'b0;

        case (state)
            IDLE: begin
                drive_n  = '0;
                do_grant = enable && arb_valid;
            end
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_n = GAP;
                    cnt_n   = '0;
                    drive_n = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            GAP: begin
                drive_n = '0;
                if (cnt == GAP_LAST) begin
                    // Back-to-back grant keeps the pulse period at HOLD_CYC+GAP_CYC.
                    do_grant = enable && arb_valid;
                    state_n  = IDLE;
                    cnt_n    = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                drive_n = '0;
            end
        endcase

        if (do_grant) begin
            grant_mask   = NCH'(onehot(32'(arb_idx)));
            state_n      = HOLD;
            cnt_n        = '0;
            drive_n      = grant_mask;
            active_idx_n = arb_idx;
            last_grant_n = arb_idx;
        end

        // A trigger in the grant cycle survives the clear so the row is served again.
        pending_n = (pending & ~grant_mask) | trig;

        // Strobe and busy are registered so they line up with drive_out.
        strobe_n = (state_n == HOLD) && (cnt_n == HOLD_LAST);
        busy_n   = (state_n != IDLE);
    end

    // State, counter, pending and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
        if (reset) begin
            // NOTE: pending is a flag vector, not a memory, and must be cleared so stale requests are never granted after reset.
            state         <= IDLE;
            cnt           <= '0;
            pending       <= '0;
            drive_out     <= '0;
            active_idx    <= '0;
            last_grant    <= LAST_ROW;
            sample_strobe <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            pending       <= pending_n;
            drive_out     <= drive_n;
            active_idx    <= active_idx_n;
            last_grant    <= last_grant_n;
            sample_strobe <= strobe_n;
            busy          <= busy_n;
        end
    end

endmodule
